// File: rtl/qam_symbol_pacer_if.sv
// Symbol handshake and status bundle between the Streamer, the pacer and the register bank.
interface qam_symbol_pacer_if #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned SYMBOL_W = 4,
    parameter int unsigned PERIOD_W = 16
);
    localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

    logic                ipEnable;
    logic [PERIOD_W-1:0] ipSymbolPeriod;
    logic [SYMBOL_W-1:0] ipSymbol;
    logic                ipSymbolValid;
    logic                opSymbolReady;
    logic                ipClearFlags;
    logic [SYMBOL_W-1:0] opQAMBlock;
    logic                opQAMBlockValid;
    logic [FILL_W-1:0]   opFill;
    logic                opUnderrun;
    logic                opOverflow;

    // Streamer / register-bank side
    modport master (
        output ipEnable,
        output ipSymbolPeriod,
        output ipSymbol,
        output ipSymbolValid,
        output ipClearFlags,
        input  opSymbolReady,
        input  opQAMBlock,
        input  opQAMBlockValid,
        input  opFill,
        input  opUnderrun,
        input  opOverflow
    );

    // Pacer side
    modport slave (
        input  ipEnable,
        input  ipSymbolPeriod,
        input  ipSymbol,
        input  ipSymbolValid,
        input  ipClearFlags,
        output opSymbolReady,
        output opQAMBlock,
        output opQAMBlockValid,
        output opFill,
        output opUnderrun,
        output opOverflow
    );
endinterface

// File: rtl/qam_symbol_pacer.sv
// Rate-controlled symbol FIFO: absorbs bursts from the Streamer and releases one symbol every
// ipSymbolPeriod clocks as a one-cycle strobe towards the QAM stage.
module qam_symbol_pacer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYMBOL_W    = 4,
    parameter int unsigned PERIOD_W    = 16,
    parameter int unsigned PRIME_LEVEL = 8
) (
    input logic              ipClk,
    input logic              ipReset,
    qam_symbol_pacer_if.slave pacer_if
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_eff;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [SYMBOL_W-1:0] mem_q [DEPTH];
    logic [SYMBOL_W-1:0] qam_q;
    logic                strobe_q;
    logic                underrun_q, overflow_q;

    logic full, empty, tick, push, pop, udr_set, ovf_set;

    // Occupancy decode and effective period (0 behaves as 1)
    always_comb begin
        full       = (fill_q == FILL_W'(DEPTH));
        empty      = (fill_q == '0);
        period_eff = (pacer_if.ipSymbolPeriod == '0) ? PERIOD_W'(1) : pacer_if.ipSymbolPeriod;
    end

    // Pacing FSM: next state, period counter and symbol tick
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        tick    = 1'b0;
        if (!pacer_if.ipEnable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StPrime;
                StPrime: begin
                    if (fill_q >= FILL_W'(PRIME_LEVEL)) state_d = StRun;
                end
                StRun: begin
                    // >= compare lets a shortened period take effect at once without wrapping
                    if (cnt_q >= period_eff - PERIOD_W'(1)) begin
                        tick = 1'b1;
                        if (empty) state_d = StPrime;
                    end else begin
                        cnt_d = cnt_q + PERIOD_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FIFO push/pop decisions; a pop frees the slot so a push at full is accepted
    always_comb begin
        pop     = tick & ~empty;
        udr_set = tick & empty;
        push    = pacer_if.ipSymbolValid & (~full | pop);
        ovf_set = pacer_if.ipSymbolValid & full & ~pop;
        fill_d  = fill_q;
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Control state, pointers, output register and sticky flags
    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            qam_q      <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            strobe_q <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                qam_q    <= mem_q[rd_ptr_q];
            end
            // A new event in the same cycle as a clear leaves the flag set
            underrun_q <= udr_set | (underrun_q & ~pacer_if.ipClearFlags);
            overflow_q <= ovf_set | (overflow_q & ~pacer_if.ipClearFlags);
        end
    end

    // Symbol storage; contents are don't-care until written, so no reset
    always_ff @(posedge ipClk) begin
        if (push) mem_q[wr_ptr_q] <= pacer_if.ipSymbol;
    end

    assign pacer_if.opSymbolReady   = ~full;
    assign pacer_if.opQAMBlock      = qam_q;
    assign pacer_if.opQAMBlockValid = strobe_q;
    assign pacer_if.opFill          = fill_q;
    assign pacer_if.opUnderrun      = underrun_q;
    assign pacer_if.opOverflow      = overflow_q;
endmodule
